// File: rtl/sd_pkg.sv
// Shared definitions for the srdy/drdy skid pipeline: per-stage state encoding and default data width.
package sd_pkg;
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } sd_state_t;

    localparam int SD_WIDTH = 8;
endpackage

// File: rtl/sd_skid_stage.sv
// One fully registered srdy/drdy stage with a main and a skid register.
// Latency 1 cycle; c_drdy drops once both registers hold words, and no word is lost.
module sd_skid_stage
    import sd_pkg::*;
#(
    parameter int width = SD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_srdy,
    input  logic [width-1:0] c_data,
    output logic             c_drdy,
    output logic             p_srdy,
    output logic [width-1:0] p_data,
    input  logic             p_drdy
);
    sd_state_t        state;
    sd_state_t        state_nxt;
    logic [width-1:0] skid;
    logic             load_main;
    logic             load_skid;
    logic             take_skid;
    logic             c_drdy_nxt;
    logic             p_srdy_nxt;
    logic             xfer_in;
    logic             xfer_out;

    assign xfer_in  = c_srdy & c_drdy;
    assign xfer_out = p_srdy & p_drdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= EMPTY;
            c_drdy <= 1'b1;
            p_srdy <= 1'b0;
            p_data <= '0;
            skid   <= '0;
        end else begin
            state  <= state_nxt;
            c_drdy <= c_drdy_nxt;
            p_srdy <= p_srdy_nxt;
            if (load_main) begin
                p_data <= c_data;
            end else if (take_skid) begin
                p_data <= skid;
            end
            if (load_skid) begin
                skid <= c_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        take_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (xfer_in) begin
                    load_main = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (xfer_in && xfer_out) begin
                    load_main = 1'b1;
                end else if (xfer_in) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (xfer_out) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                // c_drdy is low here, so the skid word is the only candidate.
                if (xfer_out) begin
                    take_skid = 1'b1;
                    state_nxt = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        c_drdy_nxt = (state_nxt != FULL);
        p_srdy_nxt = (state_nxt != EMPTY);
    end
endmodule

// File: rtl/sd_pipeline_reg.sv
// Cascade of `stages` registered skid stages between two srdy/drdy blocks.
// Latency `stages` cycles; holds 2 words per stage under backpressure, all outputs flopped.
module sd_pipeline_reg
    import sd_pkg::*;
#(
    parameter int width  = SD_WIDTH,
    parameter int stages = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_srdy,
    input  logic [width-1:0] c_data,
    output logic             c_drdy,
    output logic             p_srdy,
    output logic [width-1:0] p_data,
    input  logic             p_drdy
);
    logic             srdy [0:stages];
    logic             drdy [0:stages];
    logic [width-1:0] data [0:stages];

    assign srdy[0]      = c_srdy;
    assign data[0]      = c_data;
    assign c_drdy       = drdy[0];
    assign p_srdy       = srdy[stages];
    assign p_data       = data[stages];
    assign drdy[stages] = p_drdy;

    for (genvar g = 0; g < stages; g++) begin : g_stage
        sd_skid_stage #(
            .width(width)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .c_srdy(srdy[g]),
            .c_data(data[g]),
            .c_drdy(drdy[g]),
            .p_srdy(srdy[g+1]),
            .p_data(data[g+1]),
            .p_drdy(drdy[g+1])
        );
    end
endmodule

// File: tb/tb_sd_pipeline_reg.sv
// Bench for sd_pipeline_reg: directed pattern phases plus random traffic against a FIFO model.
module tb_sd_pipeline_reg;
    localparam int W      = 8;
    localparam int STAGES = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         c_srdy;
    logic [W-1:0] c_data;
    logic         c_drdy;
    logic         p_srdy;
    logic [W-1:0] p_data;
    logic         p_drdy;

    sd_pipeline_reg #(.width(W), .stages(STAGES)) dut (
        .clk   (clk),
        .reset (reset),
        .c_srdy(c_srdy),
        .c_data(c_data),
        .c_drdy(c_drdy),
        .p_srdy(p_srdy),
        .p_data(p_data),
        .p_drdy(p_drdy)
    );

    always #5 clk = ~clk;

    int           tests = 0;
    int           fails = 0;
    int           sent  = 0;
    int           rcvd  = 0;
    int           cyc   = 0;
    bit           saw_full = 0;
    logic [W-1:0] seq = '0;
    logic [W-1:0] q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drive inputs, score the upcoming rising edge, advance one cycle.
    task automatic step(input bit s, input bit d);
        c_srdy = s;
        c_data = seq;
        p_drdy = d;
        #1;
        if (q.size() == 0) chk("no_stale_word", p_srdy, 0);
        if (p_srdy && p_drdy && q.size() > 0) begin
            chk("data_order", p_data, q[0]);
            void'(q.pop_front());
            rcvd++;
        end
        if (c_srdy && c_drdy) begin
            q.push_back(seq);
            seq++;
            sent++;
        end
        chk("capacity", (q.size() <= 2 * STAGES), 1);
        if (!c_drdy) saw_full = 1;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_pat(input logic [7:0] sp, input logic [7:0] dp, input int n);
        for (int i = 0; i < n; i++) begin
            step(sp[cyc % 8], dp[cyc % 8]);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((q.size() > 0 || p_srdy) && guard < 100) begin
            step(1'b0, 1'b1);
            guard++;
        end
        chk("drain_empty", q.size(), 0);
        chk("drain_p_srdy", p_srdy, 0);
    endtask

    initial begin
        int gaps;
        int r0;
        bit first;
        int guard;

        reset  = 1'b0;
        c_srdy = 1'b0;
        c_data = '0;
        p_drdy = 1'b0;
        #12;
        chk("reset_p_srdy", p_srdy, 0);
        chk("reset_c_drdy", c_drdy, 1);
        chk("reset_p_data", p_data, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Single word: appears after STAGES edges for exactly one cycle.
        seq = 8'h3C;
        step(1'b1, 1'b1);
        for (int i = 1; i < STAGES; i++) begin
            chk("single_early", p_srdy, 0);
            step(1'b0, 1'b1);
        end
        chk("single_srdy", p_srdy, 1);
        chk("single_data", p_data, 8'h3C);
        step(1'b0, 1'b1);
        chk("single_once", p_srdy, 0);
        drain();

        // Streaming: one word per cycle once the pipe has filled.
        seq   = '0;
        gaps  = 0;
        first = 0;
        r0    = rcvd;
        saw_full = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1);
            if (first && !p_srdy) gaps++;
            if (p_srdy) first = 1;
        end
        chk("stream_gaps", gaps, 0);
        chk("stream_count", rcvd - r0, 20 - STAGES);
        chk("stream_no_stall", saw_full, 0);
        drain();

        // Pattern throttling.
        run_pat(8'h5A, 8'hFF, 64);
        run_pat(8'hFF, 8'hA5, 64);
        drain();

        // Overflow: producer far faster than consumer.
        saw_full = 0;
        run_pat(8'hFD, 8'h03, 100);
        chk("overflow_c_drdy_low", saw_full, 1);
        drain();

        // Underflow: consumer far faster than producer.
        r0 = rcvd;
        run_pat(8'h11, 8'hEE, 100);
        drain();
        chk("underflow_moved", (rcvd > r0), 1);
        chk("totals_match", rcvd, sent);

        // Random traffic.
        r0    = rcvd;
        guard = 0;
        while (sent < 9000 && guard < 60000) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            guard++;
        end
        chk("random_budget", (sent >= 9000), 1);
        chk("random_rcvd", (rcvd - r0 >= 1000), 1);

        // Reset mid-stream with words in flight.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        chk("pre_reset_busy", p_srdy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_reset_p_srdy", p_srdy, 0);
        chk("mid_reset_c_drdy", c_drdy, 1);
        chk("mid_reset_p_data", p_data, 0);
        q.delete();
        seq    = '0;
        c_srdy = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_p_srdy", p_srdy, 0);
        chk("post_reset_c_drdy", c_drdy, 1);
        r0 = rcvd;
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
        end
        drain();
        chk("restart_rcvd", (rcvd > r0), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
